// File: rtl/seg_digit_driver.sv
// Display pin driver: registers the scanner's digit select and nibble, decodes to active-low
// 7-segment drive, and blanks all anodes for a dead time whenever the driven digit changes.
module seg_digit_driver #(
    parameter int unsigned DEAD_CYCLES = 2000,
    parameter int unsigned CNT_W       = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] choose,
    input  logic [3:0] data,
    input  logic       blank_lz,
    input  logic [3:0] dp_mask,
    input  logic       lamp_test,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam bit               HAS_DEAD = (DEAD_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LOAD = HAS_DEAD ? CNT_W'(DEAD_CYCLES - 1) : '0;
    localparam logic [3:0]       AN_OFF   = 4'hF;
    localparam logic [6:0]       SEG_OFF  = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } state_t;

    function automatic logic [1:0] sel_idx(input logic [3:0] sel);
        case (sel)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0:    return 7'h40;
            4'h1:    return 7'h79;
            4'h2:    return 7'h24;
            4'h3:    return 7'h30;
            4'h4:    return 7'h19;
            4'h5:    return 7'h12;
            4'h6:    return 7'h02;
            4'h7:    return 7'h78;
            4'h8:    return 7'h00;
            4'h9:    return 7'h10;
            4'hA:    return 7'h08;
            4'hB:    return 7'h03;
            4'hC:    return 7'h46;
            4'hD:    return 7'h21;
            4'hE:    return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    logic [3:0]       s_choose_q, s_choose_d;
    logic [3:0]       s_data_q, s_data_d;
    state_t           state_q, state_d;
    logic [3:0]       act_q, act_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       mem_q [4];
    logic [3:0]       mem_d [4];
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic       valid;
    logic       new_sel;
    logic [1:0] act_idx;
    logic [3:0] mem_zero;
    logic       lz_hit;

    // Next state, digit memory and registered pin values
    always_comb begin
        s_choose_d = choose;
        s_data_d   = data;
        state_d    = state_q;
        act_d      = act_q;
        cnt_d      = cnt_q;
        mem_d      = mem_q;
        an_d       = AN_OFF;
        seg_d      = SEG_OFF;
        dp_d       = 1'b1;
        act_idx    = 2'd0;
        mem_zero   = 4'h0;
        lz_hit     = 1'b0;

        valid = (s_choose_q == 4'b1110) || (s_choose_q == 4'b1101) ||
                (s_choose_q == 4'b1011) || (s_choose_q == 4'b0111);

        if (valid) begin
            mem_d[sel_idx(s_choose_q)] = s_data_q;
        end

        // A valid select from IDLE, or a different one while busy, (re)starts the dead time
        new_sel = valid && ((state_q == IDLE) || (s_choose_q != act_q));

        if (new_sel) begin
            act_d = s_choose_q;
            if (HAS_DEAD) begin
                state_d = BLANK;
                cnt_d   = CNT_LOAD;
            end else begin
                state_d = DRIVE;
            end
        end else begin
            case (state_q)
                BLANK: begin
                    if (cnt_q == '0) begin
                        state_d = DRIVE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                DRIVE: begin
                    if (!valid) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Decode from the memory value being written this cycle so a data change shows 2 cycles later
        if (state_d == DRIVE) begin
            act_idx = sel_idx(act_d);
            for (int i = 0; i < 4; i++) begin
                mem_zero[i] = (mem_d[i] == 4'h0);
            end
            case (act_idx)
                2'd1:    lz_hit = &mem_zero[3:1];
                2'd2:    lz_hit = &mem_zero[3:2];
                2'd3:    lz_hit = mem_zero[3];
                default: lz_hit = 1'b0;
            endcase

            an_d = act_d;
            if (lamp_test) begin
                seg_d = 7'h00;
                dp_d  = 1'b0;
            end else begin
                seg_d = (blank_lz && lz_hit) ? SEG_OFF : hex_to_seg(mem_d[act_idx]);
                dp_d  = ~dp_mask[act_idx];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_choose_q <= 4'hF;
            s_data_q   <= 4'h0;
            state_q    <= IDLE;
            act_q      <= 4'hF;
            cnt_q      <= '0;
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= 4'h0;
            end
            an_q       <= AN_OFF;
            seg_q      <= SEG_OFF;
            dp_q       <= 1'b1;
        end else begin
            s_choose_q <= s_choose_d;
            s_data_q   <= s_data_d;
            state_q    <= state_d;
            act_q      <= act_d;
            cnt_q      <= cnt_d;
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= mem_d[i];
            end
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg_digit_driver.sv
// Directed bench for seg_digit_driver with a 4-cycle dead time; each task checks one scenario.
module tb_seg_digit_driver;

    localparam int unsigned DC = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] choose = 4'hF;
    logic [3:0] data = 4'h0;
    logic       blank_lz = 1'b0;
    logic [3:0] dp_mask = 4'h0;
    logic       lamp_test = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_cmp = 0;
    int n_err = 0;

    logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg_digit_driver #(.DEAD_CYCLES(DC), .CNT_W(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .choose    (choose),
        .data      (data),
        .blank_lz  (blank_lz),
        .dp_mask   (dp_mask),
        .lamp_test (lamp_test),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; choose = 4'hF; data = 4'h0;
        blank_lz = 1'b0; dp_mask = 4'h0; lamp_test = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic show(input logic [3:0] c, input logic [3:0] d);
        choose = c; data = d;
        repeat (DC + 2) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; choose = 4'hF;
        repeat (3) tick();
        n_cmp++;
        if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
            n_err++; $display("FAIL reset_hold: got an=%h seg=%h dp=%b exp an=f seg=7f dp=1", an, seg, dp);
        end
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_cmp++;
            if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
                n_err++; $display("FAIL reset_idle[%0d]: got an=%h seg=%h dp=%b exp an=f seg=7f dp=1", k, an, seg, dp);
            end
        end
    endtask

    task automatic test_dead_time();
        do_reset();
        choose = 4'b1110; data = 4'h5;
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_cmp++;
            if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
                n_err++; $display("FAIL dead_off[t+%0d]: got an=%h seg=%h dp=%b exp off", k, an, seg, dp);
            end
        end
        tick();
        n_cmp++;
        if ({an, seg, dp} !== {4'hE, 7'h12, 1'b1}) begin
            n_err++; $display("FAIL dead_drive: got an=%h seg=%h dp=%b exp an=e seg=12 dp=1", an, seg, dp);
        end
    endtask

    task automatic test_leading_zero();
        logic [3:0] exp_an [8]  = '{4'hE, 4'hD, 4'hB, 4'h7, 4'h7, 4'hB, 4'h7, 4'hB};
        logic [3:0] nib    [8]  = '{4'h2, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0};
        logic       lz     [8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [6:0] exp_seg[8]  = '{7'h24, 7'h79, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h79, 7'h40};
        do_reset();
        for (int k = 0; k < 8; k++) begin
            blank_lz = lz[k];
            show(exp_an[k], nib[k]);
            n_cmp++;
            if ({an, seg, dp} !== {exp_an[k], exp_seg[k], 1'b1}) begin
                n_err++; $display("FAIL lz[%0d]: got an=%h seg=%h dp=%b exp an=%h seg=%h dp=1",
                                  k, an, seg, dp, exp_an[k], exp_seg[k]);
            end
        end
    endtask

    task automatic test_data_update();
        do_reset();
        show(4'b1110, 4'h2);
        data = 4'h9;
        tick();
        n_cmp++;
        if ({an, seg} !== {4'hE, 7'h24}) begin
            n_err++; $display("FAIL upd_early: got an=%h seg=%h exp an=e seg=24", an, seg);
        end
        tick();
        n_cmp++;
        if ({an, seg} !== {4'hE, 7'h10}) begin
            n_err++; $display("FAIL upd_late: got an=%h seg=%h exp an=e seg=10", an, seg);
        end
        for (int i = 0; i < 16; i++) begin
            data = 4'(i);
            tick(); tick();
            n_cmp++;
            if ({an, seg, dp} !== {4'hE, dec_tab[i], 1'b1}) begin
                n_err++; $display("FAIL decode[%h]: got an=%h seg=%h dp=%b exp an=e seg=%h dp=1",
                                  i, an, seg, dp, dec_tab[i]);
            end
        end
    endtask

    task automatic test_restart();
        do_reset();
        show(4'b1110, 4'h8);
        choose = 4'b1101; data = 4'h3;
        tick(); tick(); tick();
        choose = 4'b1011; data = 4'h7;
        for (int m = 1; m <= 5; m++) begin
            tick();
            n_cmp++;
            if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
                n_err++; $display("FAIL restart_off[%0d]: got an=%h seg=%h dp=%b exp off", m, an, seg, dp);
            end
        end
        tick();
        n_cmp++;
        if ({an, seg, dp} !== {4'hB, 7'h78, 1'b1}) begin
            n_err++; $display("FAIL restart_drive: got an=%h seg=%h dp=%b exp an=b seg=78 dp=1", an, seg, dp);
        end
    endtask

    task automatic test_lamp();
        do_reset();
        dp_mask = 4'b0001;
        show(4'b1110, 4'h5);
        n_cmp++;
        if ({an, seg, dp} !== {4'hE, 7'h12, 1'b0}) begin
            n_err++; $display("FAIL lamp_pre: got an=%h seg=%h dp=%b exp an=e seg=12 dp=0", an, seg, dp);
        end
        lamp_test = 1'b1;
        tick();
        n_cmp++;
        if ({an, seg, dp} !== {4'hE, 7'h00, 1'b0}) begin
            n_err++; $display("FAIL lamp_on: got an=%h seg=%h dp=%b exp an=e seg=00 dp=0", an, seg, dp);
        end
        lamp_test = 1'b0; data = 4'h0;
        tick(); tick();
        n_cmp++;
        if ({an, seg, dp} !== {4'hE, 7'h40, 1'b0}) begin
            n_err++; $display("FAIL lamp_off: got an=%h seg=%h dp=%b exp an=e seg=40 dp=0", an, seg, dp);
        end
        lamp_test = 1'b1; choose = 4'b1101; data = 4'h1;
        tick();
        for (int k = 2; k <= 5; k++) begin
            tick();
            n_cmp++;
            if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
                n_err++; $display("FAIL lamp_blank[t+%0d]: got an=%h seg=%h dp=%b exp off", k, an, seg, dp);
            end
        end
        tick();
        n_cmp++;
        if ({an, seg, dp} !== {4'hD, 7'h00, 1'b0}) begin
            n_err++; $display("FAIL lamp_d1: got an=%h seg=%h dp=%b exp an=d seg=00 dp=0", an, seg, dp);
        end
        lamp_test = 1'b0;
        tick();
        n_cmp++;
        if ({an, seg, dp} !== {4'hD, 7'h79, 1'b1}) begin
            n_err++; $display("FAIL lamp_d1_off: got an=%h seg=%h dp=%b exp an=d seg=79 dp=1", an, seg, dp);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        show(4'b0111, 4'h1);
        show(4'b1110, 4'h5);
        n_cmp++;
        if ({an, seg, dp} !== {4'hE, 7'h12, 1'b1}) begin
            n_err++; $display("FAIL arst_pre: got an=%h seg=%h dp=%b exp an=e seg=12 dp=1", an, seg, dp);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
            n_err++; $display("FAIL arst_async: got an=%h seg=%h dp=%b exp off", an, seg, dp);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_cmp++;
            if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
                n_err++; $display("FAIL arst_reblank[%0d]: got an=%h seg=%h dp=%b exp off", k, an, seg, dp);
            end
        end
        tick();
        n_cmp++;
        if ({an, seg, dp} !== {4'hE, 7'h12, 1'b1}) begin
            n_err++; $display("FAIL arst_drive: got an=%h seg=%h dp=%b exp an=e seg=12 dp=1", an, seg, dp);
        end
        blank_lz = 1'b1;
        show(4'b1011, 4'h0);
        n_cmp++;
        if ({an, seg, dp} !== {4'hB, 7'h7F, 1'b1}) begin
            n_err++; $display("FAIL arst_mem_clr: got an=%h seg=%h dp=%b exp an=b seg=7f dp=1", an, seg, dp);
        end
    endtask

    initial begin
        test_reset();
        test_dead_time();
        test_leading_zero();
        test_data_update();
        test_restart();
        test_lamp();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
